// File: rtl/adc_spi_capture_if.sv
// Handshake and pin bundle between the pixel sequencer/ADC pins and adc_spi_capture.
// The slave modport is the capture block; the master modport is its environment.
interface adc_spi_capture_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  startCapture;
  logic                  miso;
  logic                  cs;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  conversionComplete;
  logic                  frameError;
  logic                  busy;
  logic                  overrun;

  modport master (
    output startCapture,
    output miso,
    input  cs,
    input  dataout,
    input  conversionComplete,
    input  frameError,
    input  busy,
    input  overrun
  );

  modport slave (
    input  startCapture,
    input  miso,
    output cs,
    output dataout,
    output conversionComplete,
    output frameError,
    output busy,
    output overrun
  );
endinterface

// File: rtl/adc_spi_capture.sv
// Serial ADC frame capture: runs cs-low frames on clk, extracts a padded MSB-first
// sample, optionally averages 2^AVG_LOG2 conversions, flags framing errors and overruns.
module adc_spi_capture #(
  parameter int DATA_WIDTH   = 8,
  parameter int LEAD_ZEROS   = 3,
  parameter int FRAME_LEN    = 16,
  parameter int QUIET_CYCLES = 1,
  parameter int AVG_LOG2     = 0
) (
  input logic              clk,
  input logic              reset,
  adc_spi_capture_if.slave bus
);

  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int BIT_W = $clog2(FRAME_LEN + 1);
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int QCT_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] LEAD_END  = BIT_W'(LEAD_ZEROS);
  localparam logic [BIT_W-1:0] DATA_END  = BIT_W'(LEAD_ZEROS + DATA_WIDTH);
  localparam logic [SMP_W-1:0] NUM_SMP   = SMP_W'(1 << AVG_LOG2);
  localparam logic [QCT_W-1:0] LAST_QCT  = QCT_W'(QUIET_CYCLES - 1);

  if ((FRAME_LEN < LEAD_ZEROS + DATA_WIDTH) || (QUIET_CYCLES < 1) || (DATA_WIDTH < 2)) begin : g_param_check
    $error("adc_spi_capture: inconsistent frame parameters");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic                  cs_q,      cs_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
  logic [QCT_W-1:0]      qct_q,     qct_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [ACC_W-1:0]      acc_q,     acc_d;
  logic                  err_q,     err_d;
  logic [DATA_WIDTH-1:0] dout_q,    dout_d;
  logic                  cc_q,      cc_d;
  logic                  fe_q,      fe_d;
  logic                  busy_q,    busy_d;
  logic                  ovr_q,     ovr_d;

  logic [ACC_W-1:0]      acc_sum_s;
  logic [SMP_W-1:0]      smp_inc_s;
  logic [SMP_W-1:0]      smp_taken_s;

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    bit_cnt_d = bit_cnt_q;
    smp_cnt_d = smp_cnt_q;
    qct_d     = qct_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    err_d     = err_q;
    dout_d    = dout_q;
    cc_d      = 1'b0;
    fe_d      = fe_q;
    busy_d    = busy_q;
    ovr_d     = bus.startCapture && (state_q != IDLE);

    acc_sum_s = acc_q + ACC_W'(shift_q);
    smp_inc_s = smp_cnt_q + SMP_W'(1);
    // Samples accounted for once this edge completes, used for the exit decision
    smp_taken_s = (qct_q == QCT_W'(0)) ? smp_inc_s : smp_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.startCapture) begin
          state_d   = CONV;
          cs_d      = 1'b0;
          bit_cnt_d = BIT_W'(0);
          smp_cnt_d = SMP_W'(0);
          acc_d     = ACC_W'(0);
          err_d     = 1'b0;
          busy_d    = 1'b1;
        end else begin
          cs_d   = 1'b1;
          busy_d = 1'b0;
        end
      end

      CONV: begin
        if (bit_cnt_q < LEAD_END) begin
          err_d = err_q | bus.miso;
        end else if (bit_cnt_q < DATA_END) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], bus.miso};
        end else begin
          shift_d = shift_q;
        end

        if (bit_cnt_q == LAST_BIT) begin
          state_d   = QUIET;
          cs_d      = 1'b1;
          bit_cnt_d = BIT_W'(0);
          qct_d     = QCT_W'(0);
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      QUIET: begin
        if (qct_q == QCT_W'(0)) begin
          acc_d     = acc_sum_s;
          smp_cnt_d = smp_inc_s;
          if (smp_inc_s == NUM_SMP) begin
            dout_d = acc_sum_s[ACC_W-1:AVG_LOG2];
            fe_d   = err_q;
            cc_d   = 1'b1;
          end else begin
            cc_d = 1'b0;
          end
        end else begin
          acc_d = acc_q;
        end

        if (qct_q == LAST_QCT) begin
          if (smp_taken_s != NUM_SMP) begin
            state_d   = CONV;
            cs_d      = 1'b0;
            bit_cnt_d = BIT_W'(0);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          qct_d = qct_q + QCT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset forces cs high immediately so an interrupted frame is released at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cs_q      <= 1'b1;
      bit_cnt_q <= BIT_W'(0);
      smp_cnt_q <= SMP_W'(0);
      qct_q     <= QCT_W'(0);
      shift_q   <= DATA_WIDTH'(0);
      acc_q     <= ACC_W'(0);
      err_q     <= 1'b0;
      dout_q    <= DATA_WIDTH'(0);
      cc_q      <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      bit_cnt_q <= bit_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      qct_q     <= qct_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      cc_q      <= cc_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.cs                 = cs_q;
  assign bus.dataout            = dout_q;
  assign bus.conversionComplete = cc_q;
  assign bus.frameError         = fe_q;
  assign bus.busy               = busy_q;
  assign bus.overrun            = ovr_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: default, averaging (AVG_LOG2=2) and 12-bit
// configurations driven frame by frame with hand-computed expectations.
module tb_adc_spi_capture;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  adc_spi_capture_if #(.DATA_WIDTH(8))  if0 ();
  adc_spi_capture_if #(.DATA_WIDTH(8))  if1 ();
  adc_spi_capture_if #(.DATA_WIDTH(12)) if2 ();

  adc_spi_capture dut0 (.clk(clk), .reset(reset), .bus(if0));
  adc_spi_capture #(.AVG_LOG2(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  adc_spi_capture #(.DATA_WIDTH(12), .LEAD_ZEROS(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_cs(input int w);
    case (w)
      0:       return if0.cs;
      1:       return if1.cs;
      default: return if2.cs;
    endcase
  endfunction

  function automatic logic get_cc(input int w);
    case (w)
      0:       return if0.conversionComplete;
      1:       return if1.conversionComplete;
      default: return if2.conversionComplete;
    endcase
  endfunction

  function automatic logic get_ovr(input int w);
    case (w)
      0:       return if0.overrun;
      1:       return if1.overrun;
      default: return if2.overrun;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic get_fe(input int w);
    case (w)
      0:       return if0.frameError;
      1:       return if1.frameError;
      default: return if2.frameError;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int w);
    case (w)
      0:       return 32'(if0.dataout);
      1:       return 32'(if1.dataout);
      default: return 32'(if2.dataout);
    endcase
  endfunction

  task automatic set_miso(input int w, input logic b);
    case (w)
      0:       if0.miso = b;
      1:       if1.miso = b;
      default: if2.miso = b;
    endcase
  endtask

  task automatic set_start(input int w, input logic b);
    case (w)
      0:       if0.startCapture = b;
      1:       if1.startCapture = b;
      default: if2.startCapture = b;
    endcase
  endtask

  // Called at the negedge after the edge that entered CONV; returns after the last sampling edge
  task automatic run_frame(input int w, input logic [15:0] bits, input int pulse_k,
                           inout int low_cnt, inout int cc_cnt, inout int ovr_cnt);
    for (int k = 0; k < 16; k++) begin
      if (get_cs(w) == 1'b0) low_cnt++;
      if (get_cc(w)) cc_cnt++;
      if (get_ovr(w)) ovr_cnt++;
      set_miso(w, bits[15-k]);
      set_start(w, (k == pulse_k));
      @(negedge clk);
    end
    set_start(w, 1'b0);
    set_miso(w, 1'b0);
  endtask

  task automatic single(input int w, input logic [15:0] bits, input logic [31:0] exp_d,
                        input logic exp_fe, input string tag);
    int lo = 0;
    int cc = 0;
    int ov = 0;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    run_frame(w, bits, -1, lo, cc, ov);
    check_eq({tag, "_cs_low_cycles"}, 32'(lo), 32'd16);
    check_eq({tag, "_cc_early"}, 32'(cc) + 32'(get_cc(w)), 32'd0);
    check_eq({tag, "_cs_released"}, 32'(get_cs(w)), 32'd1);
    @(negedge clk);
    check_eq({tag, "_cc"}, 32'(get_cc(w)), 32'd1);
    check_eq({tag, "_data"}, get_data(w), exp_d);
    check_eq({tag, "_fe"}, 32'(get_fe(w)), 32'(exp_fe));
    check_eq({tag, "_busy_fall"}, 32'(get_busy(w)), 32'd0);
    @(negedge clk);
    check_eq({tag, "_cc_one_cycle"}, 32'(get_cc(w)), 32'd0);
  endtask

  initial begin
    int lo;
    int cc;
    int ov;
    int gaps;
    int extra_low;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int w = 0; w < 3; w++) begin
      set_start(w, 1'b0);
      set_miso(w, 1'b0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_cs",   32'(get_cs(0)),   32'd1);
    check_eq("rst_data", get_data(0),      32'd0);
    check_eq("rst_cc",   32'(get_cc(0)),   32'd0);
    check_eq("rst_fe",   32'(get_fe(0)),   32'd0);
    check_eq("rst_busy", 32'(get_busy(0)), 32'd0);
    check_eq("rst_ovr",  32'(get_ovr(0)),  32'd0);

    // 000_10100101_00000
    single(0, 16'h14A0, 32'h0000_00A5, 1'b0, "a5");
    // Lead bit 1 set, data 0x3C, then the same data with clean lead bits
    single(0, 16'h4780, 32'h0000_003C, 1'b1, "err");
    single(0, 16'h0780, 32'h0000_003C, 1'b0, "clean");

    // Overrun: start pulsed at frame bit 5 and on the return-to-IDLE edge
    lo = 0; cc = 0; ov = 0; extra_low = 0;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    run_frame(0, 16'h0140, 5, lo, cc, ov);
    cc += int'(get_cc(0));
    ov += int'(get_ovr(0));
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    cc += int'(get_cc(0));
    ov += int'(get_ovr(0));
    check_eq("ovr_data", get_data(0), 32'h0000_000A);
    check_eq("ovr_busy_fall", 32'(get_busy(0)), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (get_cs(0) == 1'b0) extra_low++;
      cc += int'(get_cc(0));
      ov += int'(get_ovr(0));
    end
    check_eq("ovr_pulses", 32'(ov), 32'd2);
    check_eq("ovr_cc_count", 32'(cc), 32'd1);
    check_eq("ovr_cs_low_cycles", 32'(lo), 32'd16);
    check_eq("ovr_no_extra_frame", 32'(extra_low), 32'd0);

    // Reset at frame bit 7: cs must rise without waiting for a clock edge
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      set_miso(0, 1'b1);
      @(negedge clk);
    end
    check_eq("midrst_cs_before", 32'(get_cs(0)), 32'd0);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_cs_async", 32'(get_cs(0)), 32'd1);
    check_eq("midrst_data", get_data(0), 32'd0);
    check_eq("midrst_busy", 32'(get_busy(0)), 32'd0);
    set_miso(0, 1'b0);
    cc = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cc += int'(get_cc(0));
    end
    reset = 1'b0;
    @(negedge clk);
    cc += int'(get_cc(0));
    check_eq("midrst_no_cc", 32'(cc), 32'd0);
    single(0, 16'h0B40, 32'h0000_005A, 1'b0, "after_rst");

    // Averaging over four frames 0x10..0x13
    lo = 0; cc = 0; ov = 0; gaps = 0;
    set_start(1, 1'b1);
    @(negedge clk);
    set_start(1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      run_frame(1, {3'b000, 8'h10 + 8'(s), 5'b00000}, -1, lo, cc, ov);
      cc += int'(get_cc(1));
      if (get_cs(1)) gaps++;
      @(negedge clk);
    end
    check_eq("avg_cs_low_cycles", 32'(lo), 32'd64);
    check_eq("avg_gaps", 32'(gaps), 32'd4);
    check_eq("avg_cc_early", 32'(cc), 32'd0);
    check_eq("avg_cc", 32'(get_cc(1)), 32'd1);
    check_eq("avg_data", get_data(1), 32'h0000_0011);
    check_eq("avg_busy_fall", 32'(get_busy(1)), 32'd0);
    @(negedge clk);
    check_eq("avg_cc_one_cycle", 32'(get_cc(1)), 32'd0);

    // 12-bit sample, four lead zeros: 0000_101111001101
    single(2, 16'h0BCD, 32'h0000_0BCD, 1'b0, "w12");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
